// File: rtl/seven_seg_pkg.sv
// Seven-segment constants and BCD decoder shared by the display blocks.
// Segment order is {g,f,e,d,c,b,a}, with segment a on bit 0; a 1 means the segment is lit.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/pulse_divider.sv
// Counts qualifying input pulses modulo DIV.
// out_pulse is combinational and is high in the cycle whose clock edge wraps the count.
module pulse_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_pulse,
  input  logic hold,
  output logic out_pulse
);

  generate
    if (DIV > 1) begin : g_count
      localparam int W = $clog2(DIV);
      logic [W-1:0] cnt;
      logic         at_top;

      assign at_top    = (cnt == W'(DIV - 1));
      assign out_pulse = in_pulse && !hold && at_top;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (in_pulse && !hold) begin
          cnt <= at_top ? '0 : cnt + 1'b1;
        end
      end
    end else begin : g_pass
      // With DIV = 1 every qualifying input pulse is passed straight through, so no counter is needed.
      assign out_pulse = in_pulse && !hold;
    end
  endgenerate

endmodule

// File: rtl/bcd_second_counter_scan.sv
// N-digit BCD up/down tick counter with clear/load.
// Drives a time-multiplexed seven-segment display directly.
module bcd_second_counter_scan
  import seven_seg_pkg::*;
#(
  parameter int CLKS_PER_MS = 100000,
  parameter int MS_PER_TICK = 1000,
  parameter int N_DIGITS    = 4,
  parameter int SCAN_MS     = 1,
  parameter int ACTIVE_LOW  = 1,
  parameter int BLANK_LZ    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    up,
  input  logic                    clear,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_val,
  output logic [4*N_DIGITS-1:0]   bcd,
  output logic                    tick,
  output logic                    wrap,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an
);

  localparam int DW    = 4 * N_DIGITS;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam bit INV   = (ACTIVE_LOW != 0);

  logic ms_wrap, ms_pulse, tick_due, scan_due, tick_rst_n;

  pulse_divider #(.DIV(CLKS_PER_MS)) u_ms_div (
    .clk(clk), .rst_n(rst_n), .in_pulse(1'b1), .hold(1'b0), .out_pulse(ms_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) ms_pulse <= 1'b0;
    else        ms_pulse <= ms_wrap;
  end

  // clear restarts the sub-tick phase, so it acts as an extra synchronous reset on that divider.
  assign tick_rst_n = rst_n && !clear;

  pulse_divider #(.DIV(MS_PER_TICK)) u_tick_div (
    .clk(clk), .rst_n(tick_rst_n), .in_pulse(ms_pulse), .hold(!en), .out_pulse(tick_due)
  );

  pulse_divider #(.DIV(SCAN_MS)) u_scan_div (
    .clk(clk), .rst_n(rst_n), .in_pulse(ms_pulse), .hold(1'b0), .out_pulse(scan_due)
  );

  logic [N_DIGITS-1:0] is_nine, is_zero, carry, blank;
  logic [DW-1:0]       bcd_next, load_sat;
  logic                wrap_due;

  generate
    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
      logic [3:0] d, ld;
      assign d          = bcd[4*k +: 4];
      assign ld         = load_val[4*k +: 4];
      assign is_nine[k] = (d == 4'd9);
      assign is_zero[k] = (d == 4'd0);

      if (k == 0) begin : g_lsd
        assign carry[k] = 1'b1;
        assign blank[k] = 1'b0;
      end else begin : g_upper
        // A digit moves only when every digit below it is rolling over.
        assign carry[k] = up ? (&is_nine[k-1:0]) : (&is_zero[k-1:0]);
        assign blank[k] = (BLANK_LZ != 0) && (bcd[DW-1:4*k] == '0);
      end

      assign bcd_next[4*k +: 4] = !carry[k] ? d :
                                  up ? ((d == 4'd9) ? 4'd0 : d + 4'd1)
                                     : ((d == 4'd0) ? 4'd9 : d - 4'd1);
      assign load_sat[4*k +: 4] = (ld > 4'd9) ? 4'd9 : ld;
    end
  endgenerate

  assign wrap_due = up ? (&is_nine) : (&is_zero);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      bcd  <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (load) begin
      bcd  <= load_sat;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else if (tick_due) begin
      bcd  <= bcd_next;
      tick <= 1'b1;
      wrap <= wrap_due;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end

  // scan_live stays low after reset so that no anode lights before the first scan step.
  logic [IDX_W-1:0] scan_idx;
  logic             scan_live;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_idx  <= '0;
      scan_live <= 1'b0;
    end else if (scan_due) begin
      scan_live <= 1'b1;
      scan_idx  <= (scan_idx == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  logic [3:0]          sel_digit;
  logic                sel_blank;
  logic [N_DIGITS-1:0] an_next;
  logic [6:0]          seg_next;

  always_comb begin
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    an_next   = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (scan_idx == IDX_W'(k)) begin
        sel_digit  = bcd[4*k +: 4];
        sel_blank  = blank[k];
        an_next[k] = 1'b1;
      end
    end
    if (!scan_live) an_next = '0;
    seg_next = (scan_live && !sel_blank) ? bcd_to_seg(sel_digit) : SEG_BLANK;
  end

  // Polarity is applied only here; everything upstream of this register uses active-high logic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an  <= {N_DIGITS{INV}};
      seg <= {7{INV}};
    end else begin
      an  <= an_next ^ {N_DIGITS{INV}};
      seg <= seg_next ^ {7{INV}};
    end
  end

endmodule
